regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 32 x 32-bit register file between three writeback requesters: 0 = ALU, 1 = load unit, 2 = MMIO/audio unit. Grants use a rotating (round-robin) priority. Each winning request is driven onto the register file write bus as a registered one-cycle write. An optional 32-entry pending-write scoreboard lets issue logic detect RAW hazards on registers that still await writeback.

---
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus for regfile_wb_arbiter: requester handshake, register-file write port
// and pending-write scoreboard. The master modport is the requester/issue side.
interface regfile_wb_arbiter_if;
   logic [2:0]  req_valid;
   logic [14:0] req_reg;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        RegWrite;
   logic [4:0]  Write_Reg;
   logic [31:0] Write_Bus;
   logic [1:0]  grant_id;
   logic        rsv_valid;
   logic [4:0]  rsv_reg;
   logic [31:0] pending;

   modport master (
      output req_valid, req_reg, req_data, rsv_valid, rsv_reg,
      input  req_ready, RegWrite, Write_Reg, Write_Bus, grant_id, pending
   );

   modport slave (
      input  req_valid, req_reg, req_data, rsv_valid, rsv_reg,
      output req_ready, RegWrite, Write_Reg, Write_Bus, grant_id, pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among ALU, load and MMIO writeback.
// Optional pending-write scoreboard built when RF_WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter (
   input  logic                clk,
   input  logic                rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam int         NUM_REQ = 3;
   localparam int         DATA_W  = 32;
   localparam int         REG_W   = 5;
   localparam logic [1:0] IDLE_ID = 2'b11;

   // (a + b) mod NUM_REQ for operands already below NUM_REQ
   function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'(NUM_REQ)) ? 2'(s - 3'(NUM_REQ)) : s[1:0];
   endfunction

   logic [1:0]         rr_ptr;
   logic [1:0]         win;
   logic [1:0]         idx;
   logic               xfer;
   logic [NUM_REQ-1:0] ready;
   logic [REG_W-1:0]   sel_reg;
   logic [DATA_W-1:0]  sel_data;

   logic               wb_en;
   logic [REG_W-1:0]   wb_reg;
   logic [DATA_W-1:0]  wb_data;
   logic [1:0]         wb_id;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      ready = '0;
      win   = '0;
      xfer  = 1'b0;
      idx   = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = wrap_add(rr_ptr, 2'(k));
         if (!xfer && bus.req_valid[idx]) begin
            xfer = 1'b1;
            win  = idx;
         end
      end
      if (xfer) ready[win] = 1'b1;
   end

   assign sel_reg       = bus.req_reg[REG_W*win +: REG_W];
   assign sel_data      = bus.req_data[DATA_W*win +: DATA_W];
   assign bus.req_ready = ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         wb_en   <= 1'b0;
         wb_reg  <= '0;
         wb_data <= '0;
         wb_id   <= IDLE_ID;
      end else if (xfer) begin
         rr_ptr  <= wrap_add(win, 2'd1);
         wb_en   <= (sel_reg != '0);
         wb_reg  <= sel_reg;
         wb_data <= sel_data;
         wb_id   <= win;
      end else begin
         wb_en   <= 1'b0;
         wb_id   <= IDLE_ID;
      end
   end

   assign bus.RegWrite  = wb_en;
   assign bus.Write_Reg = wb_reg;
   assign bus.Write_Bus = wb_data;
   assign bus.grant_id  = wb_id;

`ifdef RF_WB_SCOREBOARD_EN
   logic [31:0] pend_q;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (bus.rsv_valid && bus.rsv_reg != '0) set_mask[bus.rsv_reg] = 1'b1;
      if (xfer && sel_reg != '0)              clr_mask[sel_reg]     = 1'b1;
   end

   // Set is applied after clear: a same-cycle reservation is younger than the retiring write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= (pend_q & ~clr_mask) | set_mask;
   end

   assign bus.pending = pend_q;
`else
   logic unused_rsv;
   assign unused_rsv  = ^{bus.rsv_valid, bus.rsv_reg};
   assign bus.pending = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic,
// compared against a cycle-level behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef RF_WB_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state
   int          m_ptr;
   logic        m_we;
   logic [4:0]  m_wreg;
   logic [31:0] m_wbus;
   logic [1:0]  m_gid;
   logic [31:0] m_pend;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_we   = 1'b0;
      m_wreg = '0;
      m_wbus = '0;
      m_gid  = 2'b11;
      m_pend = '0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".RegWrite"},  {31'd0, bus.RegWrite}, {31'd0, m_we});
      check({tag, ".Write_Reg"}, {27'd0, bus.Write_Reg}, {27'd0, m_wreg});
      check({tag, ".Write_Bus"}, bus.Write_Bus, m_wbus);
      check({tag, ".grant_id"},  {30'd0, bus.grant_id}, {30'd0, m_gid});
      check({tag, ".pending"},   bus.pending, SB_EN ? m_pend : 32'h0);
   endtask

   // One clock cycle: drive at negedge, check ready, then check registered results after posedge.
   task automatic step(input string tag, input logic [2:0] v, input logic [14:0] r,
                       input logic [95:0] d, input logic rv, input logic [4:0] rr);
      int         w;
      int         idx;
      logic [2:0] exp_rdy;
      logic [4:0] dst;
      @(negedge clk);
      bus.req_valid = v;
      bus.req_reg   = r;
      bus.req_data  = d;
      bus.rsv_valid = rv;
      bus.rsv_reg   = rr;
      #1;
      w = -1;
      for (int k = 0; k < 3; k++) begin
         idx = (m_ptr + k) % 3;
         if (w < 0 && v[idx]) w = idx;
      end
      exp_rdy = (w >= 0) ? (3'b001 << w) : 3'b000;
      check({tag, ".req_ready"}, {29'd0, bus.req_ready}, {29'd0, exp_rdy});
      @(posedge clk);
      #1;
      if (w >= 0) begin
         dst    = r[5*w +: 5];
         m_ptr  = (w + 1) % 3;
         m_we   = (dst != 5'd0);
         m_wreg = dst;
         m_wbus = d[32*w +: 32];
         m_gid  = 2'(w);
         if (dst != 5'd0) m_pend[dst] = 1'b0;
      end else begin
         m_we  = 1'b0;
         m_gid = 2'b11;
      end
      if (rv && rr != 5'd0) m_pend[rr] = 1'b1;
      check_outputs(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_gid [6];
      exp_gid = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

      bus.req_valid = '0;
      bus.req_reg   = '0;
      bus.req_data  = '0;
      bus.rsv_valid = 1'b0;
      bus.rsv_reg   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Full contention on registers 5, 6, 7
      for (int c = 0; c < 6; c++) begin
         step("contend", 3'b111, {5'd7, 5'd6, 5'd5},
              {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000}, 1'b0, 5'd0);
         check("contend.order", {30'd0, bus.grant_id}, {30'd0, exp_gid[c]});
         check("contend.reg", {27'd0, bus.Write_Reg}, 32'd5 + {30'd0, exp_gid[c]});
      end

      // Requester 1 alone
      step("r1_alone", 3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0}, 1'b0, 5'd0);
      check("r1_alone.bus", bus.Write_Bus, 32'hDEAD_BEEF);

      // Requester 2 writes r0: accepted, no RegWrite, pointer wraps to 0
      step("r2_r0", 3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234_5678, 32'h0, 32'h0}, 1'b0, 5'd0);
      check("r2_r0.we", {31'd0, bus.RegWrite}, 32'd0);
      step("after_r0", 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0);
      check("after_r0.gid", {30'd0, bus.grant_id}, 32'd0);

      // Scoreboard: reserve r12, idle, write r12 while re-reserving it
      step("rsv12", 3'b000, '0, '0, 1'b1, 5'd12);
      step("idle0", 3'b000, '0, '0, 1'b0, 5'd0);
      step("idle1", 3'b000, '0, '0, 1'b0, 5'd0);
      step("wr12_rsv12", 3'b001, {5'd0, 5'd0, 5'd12}, {64'h0, 32'hABCD_0012}, 1'b1, 5'd12);
      step("rsv4", 3'b000, '0, '0, 1'b1, 5'd4);
      step("wr4", 3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h0000_0044, 32'h0}, 1'b0, 5'd0);
      step("rsv0", 3'b000, '0, '0, 1'b1, 5'd0);

      // Asynchronous reset mid-operation with requester 2 waiting
      @(negedge clk);
      bus.req_valid = 3'b100;
      bus.req_reg   = {5'd8, 5'd0, 5'd0};
      bus.req_data  = {32'h8888_8888, 64'h0};
      bus.rsv_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      check("async_rst.req_ready", {29'd0, bus.req_ready}, 32'b100);
      @(posedge clk);
      #1;
      check_outputs("held_rst");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", 3'b111, {5'd7, 5'd6, 5'd5}, {32'h2, 32'h1, 32'h0}, 1'b0, 5'd0);
      check("post_rst.gid", {30'd0, bus.grant_id}, 32'd0);

      // Randomized traffic
      for (int c = 0; c < 300; c++) begin
         step("rand", 3'($urandom), 15'($urandom),
              {$urandom, $urandom, $urandom}, ($urandom_range(0, 2) == 0), 5'($urandom));
      end

      @(negedge clk);
      bus.req_valid = '0;
      bus.rsv_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
